// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked pipeline-stage register with an optional skid entry.
//
// Holds one packed payload between two pipeline stages using a valid/ready handshake.
// With SKID=1 a second (skid) entry absorbs the beat that arrives while the downstream
// stalls, so in_ready_o depends only on local state, not on out_ready_i. With SKID=0
// the stage has one entry and in_ready_o follows out_ready_i combinationally.
// Flush drops every held entry and any beat offered in the same cycle. Hold freezes
// the stage.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-low reset
//   flush_i      drop all held entries this cycle (wins over hold_i)
//   hold_i       freeze the stage: no transfers, state unchanged
//   in_valid_i   upstream payload valid
//   in_ready_o   stage accepts a payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  main entry valid and not held
//   out_ready_i  downstream accepts
//   out_data_o   main entry payload (BUBBLE_VAL when empty)
//   occupancy_o  number of valid entries, 0..2
module pipe_stage_hs #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] BUBBLE_VAL = 32'h00000013,
  parameter bit          SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  // Bubble value truncated or zero-extended to the payload width.
  localparam logic [DATA_W-1:0] BubbleW = DATA_W'(BUBBLE_VAL);

  logic              mv_q, mv_d;
  logic              sv_q, sv_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic [DATA_W-1:0] sd_q, sd_d;

  logic ready_core;
  logic in_fire;
  logic out_fire;

  // SKID=1: accept whenever the skid entry is free; no path from out_ready_i.
  always_comb begin
    if (SKID) begin
      ready_core = ~sv_q;
    end else begin
      ready_core = ~mv_q | out_ready_i;
    end
  end

  // Outputs are gated by rst so nothing handshakes while reset is asserted.
  assign in_ready_o  = rst & ready_core & ~hold_i & ~flush_i;
  assign out_valid_o = rst & mv_q & ~hold_i;
  assign out_data_o  = md_q;
  assign occupancy_o = {1'b0, mv_q} + {1'b0, sv_q};

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    mv_d = mv_q;
    sv_d = sv_q;
    md_d = md_q;
    sd_d = sd_q;
    if (flush_i) begin
      mv_d = 1'b0;
      sv_d = 1'b0;
      md_d = BubbleW;
      sd_d = BubbleW;
    end else if (hold_i) begin
      // Freeze: keep everything.
    end else if (out_fire) begin
      if (sv_q) begin
        // Skid entry moves up; refill it from the input if a beat arrives.
        md_d = sd_q;
        if (in_fire) begin
          sd_d = in_data_i;
        end else begin
          sv_d = 1'b0;
          sd_d = BubbleW;
        end
      end else if (in_fire) begin
        md_d = in_data_i;
      end else begin
        mv_d = 1'b0;
        md_d = BubbleW;
      end
    end else if (!mv_q) begin
      if (in_fire) begin
        mv_d = 1'b1;
        md_d = in_data_i;
      end
    end else if (in_fire && SKID) begin
      // Main entry stalled: park the incoming beat in the skid entry.
      sv_d = 1'b1;
      sd_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mv_q <= 1'b0;
      sv_q <= 1'b0;
      md_q <= BubbleW;
      sd_q <= BubbleW;
    end else begin
      mv_q <= mv_d;
      sv_q <= sv_d;
      md_q <= md_d;
      sd_q <= sd_d;
    end
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
Parametrised, handshaked pipeline-stage register that replaces the fixed hold-only inter-stage registers (IF/ID, ID/EX, EX/MEM).
- Carries one packed payload bus between two stages.
- Uses a valid/ready handshake.
- Has an optional skid entry, so full throughput is kept under backpressure without a combinational ready path.
- Supports flush (bubble insertion) and hold (freeze) driven by the control unit.

Parameters:
DATA_W, 32, payload width in bits; the stage owner packs inst/addr/operands/control into it.
BUBBLE_VAL, 32'h00000013, value out_data_o takes when the stage is empty (INST_NOP in the low 32 bits when DATA_W>=32; truncated or zero-extended otherwise).
SKID, 1, 1 = two-entry (main + skid) stage with registered in_ready_o; 0 = single entry, in_ready_o combinational from out_ready_i.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-low reset.
flush_i  in  1  kill all held entries this cycle (branch/jump taken).
hold_i  in  1  freeze stage (load-use stall).
in_valid_i  in  1  upstream payload valid.
in_ready_o  out  1  stage can accept this cycle.
in_data_i  in  DATA_W  upstream payload.
out_valid_o  out  1  payload in main entry is valid.
out_ready_i  in  1  downstream accepts.
out_data_o  out  DATA_W  main-entry payload.
occupancy_o  out  2  number of valid entries (0..2; max 1 when SKID=0).

Behaviour:
- Terms: M = main entry (valid bit mv, data md); S = skid entry (sv, sd; absent when SKID=0).
- Handshake events:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Reset (rst==0 at posedge):
  - mv=0, sv=0, md=BUBBLE_VAL, sd=BUBBLE_VAL.
  - While rst==0: in_ready_o=0 and out_valid_o=0.
  - Reset overrides flush and hold and may assert mid-transfer; no partial state survives.
- Output mapping: out_valid_o = mv & ~hold_i; out_data_o = md; occupancy_o = mv + sv.
- in_ready_o:
  - SKID=1: ~sv & ~hold_i & ~flush_i.
  - SKID=0: (~mv | out_ready_i) & ~hold_i & ~flush_i.
- Priority (highest first): reset, flush, hold, normal.
- Flush:
  - mv=0, sv=0, md=BUBBLE_VAL next cycle.
  - An input presented in the flush cycle is dropped (in_ready_o=0).
  - Flush with hold_i=1 still flushes.
- Hold: all state unchanged; no in_fire, no out_fire; out_data_o keeps its value.
- Normal update, SKID=1:
  - out_fire & sv: M<=S, and if in_fire then S<=input, else sv=0.
  - out_fire & ~sv: if in_fire then M<=input, else mv=0 and md<=BUBBLE_VAL.
  - ~out_fire & ~mv: if in_fire then M<=input.
  - ~out_fire & mv: if in_fire then S<=input.
- Normal update, SKID=0: same rules with S never valid.
- Latency and throughput:
  - Input to out_valid_o is 1 cycle.
  - Sustained 1 transfer/cycle when out_ready_i=1.
  - FIFO order is always preserved; no payload is duplicated or lost except by flush.
- Boundary cases:
  - Full (occupancy 2) with out_ready_i=0: in_ready_o=0; data is stable.
  - Full with out_fire: M takes S and in_ready_o rises next cycle.
  - Empty: out_data_o==BUBBLE_VAL.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=0, out_data_o=0x13, occupancy_o=0; after release in_ready_o=1.
- Stream: out_ready_i=1; drive 0xA0,0xA1,0xA2 on consecutive cycles -> out_data_o shows 0xA0,0xA1,0xA2 one cycle later each, out_valid_o continuous, occupancy_o=1.
- Backpressure (SKID=1): out_ready_i=0, drive 0xB0,0xB1,0xB2 -> 0xB0 in M, 0xB1 in S, occupancy_o=2, in_ready_o=0 so 0xB2 stalls; raise out_ready_i -> order 0xB0,0xB1,0xB2 with no loss.
- Flush: occupancy 2 (0xC0,0xC1), flush_i=1 with in_valid_i=1 (0xC2) -> next cycle occupancy_o=0, out_valid_o=0, out_data_o=0x13, 0xC2 not captured.
- Hold: M=0xD0, hold_i=1 for 3 cycles with out_ready_i=1 and in_valid_i=1 -> out_valid_o=0, in_ready_o=0, out_data_o=0xD0 throughout; release -> 0xD0 fires next.
- SKID=0 variant: out_ready_i=0 with M full -> in_ready_o=0 the same cycle; raising out_ready_i raises in_ready_o combinationally and allows back-to-back transfer.
